teclado_digitos: RTL and testbench

- Producer side of the digit interface consumed by setup and the operational lock logic.
- Scans a 4x4 matrix keypad, debounces each press and decodes it to a BCD/key nibble.
- Shifts the nibble into a 20-digit buffer (senhaPac_t) and emits a one-cycle digitos_valid per accepted key.
- Clears the buffer to all-0xF after '*' (0xA) or '#' (0xB).

---
 rtl/teclado_digitos_pkg.sv | 69 ++++++
 rtl/teclado_digitos_debounce.sv | 42 ++++
 rtl/teclado_digitos.sv | 184 ++++++++++++++++++
 tb/tb_teclado_digitos.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_digitos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : teclado_digitos_pkg
// Description : Shared lock package. Holds the 20-digit password buffer type,
//               the special key codes, the keypad FSM state encoding and the
//               keypad key-map decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package teclado_digitos_pkg;

  localparam int NUM_DIGITS = 20;

  // digits[0] is the newest nibble and sits in the least significant bits.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
  } senhaPac_t;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;
  localparam logic [3:0] KEY_EMPTY = 4'hF;

  localparam logic [NUM_DIGITS*4-1:0] ALL_EMPTY = '1;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    PRESS_DB = 3'd1,
    EMIT     = 3'd2,
    CLEAR    = 3'd3,
    REL_DB   = 3'd4
  } teclado_state_t;

  // Index of the single zero in a one-cold 4-bit vector.
  function automatic logic [1:0] cold_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Returns {valid, code}; the letter column (A-D) decodes as not valid.
  function automatic logic [4:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] k;
    k = {1'b0, KEY_EMPTY};
    case ({row, col})
      4'h0: k = {1'b1, 4'h1};
      4'h1: k = {1'b1, 4'h2};
      4'h2: k = {1'b1, 4'h3};
      4'h4: k = {1'b1, 4'h4};
      4'h5: k = {1'b1, 4'h5};
      4'h6: k = {1'b1, 4'h6};
      4'h8: k = {1'b1, 4'h7};
      4'h9: k = {1'b1, 4'h8};
      4'hA: k = {1'b1, 4'h9};
      4'hC: k = {1'b1, KEY_STAR};
      4'hD: k = {1'b1, 4'h0};
      4'hE: k = {1'b1, KEY_HASH};
      default: k = {1'b0, KEY_EMPTY};
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/teclado_digitos_debounce.sv
`default_nettype none
// ============================================================================
// Module      : teclado_debounce
// Description : Generic stable-level counter. Asserts stable on the CYCLES-th
//               consecutive cycle in which sample is high; any low sample or
//               a restart clears the count.
// Ports       : clk     - system clock
//               rst     - asynchronous active-low reset
//               sample  - level condition being qualified
//               restart - forces the count back to zero
//               stable  - one-cycle indication that the level has held
// Revision    : 1.0 - initial release
// ============================================================================
module teclado_debounce #(
  parameter int CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic restart,
  output logic stable
);

  localparam int            CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  assign stable = sample && !restart && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || !sample || stable) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/teclado_digitos.sv
`default_nettype none
// ============================================================================
// Module      : teclado_digitos
// Description : 4x4 matrix keypad scanner. Debounces press and release,
//               decodes the key and shifts it into a 20-digit buffer with a
//               one-cycle digitos_valid per accepted key. '*' and '#' clear
//               the buffer one cycle after their pulse.
// Ports       : clk           - system clock
//               rst           - asynchronous active-low reset
//               col_in[3:0]   - keypad columns, active-low, asynchronous
//               row_out[3:0]  - keypad rows, one-cold
//               digitos_value - digit buffer, digits[0] newest
//               digitos_valid - one-cycle pulse, value valid in same cycle
// Options     : TECLADO_TIMEOUT_EN - flush a stale buffer after
//               TIMEOUT_CYCLES idle scan cycles
// Revision    : 1.0 - initial release
// ============================================================================
module teclado_digitos
  import teclado_digitos_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int TIMEOUT_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Out-of-range configurations are flagged by this marker block.
  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_out_of_range
  end

  teclado_state_t   state, state_next;
  logic [3:0]       col_meta, col_sync;
  logic [3:0]       row_d1, row_d2;
  logic [3:0]       key_row, key_col;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       key_dec;
  logic             aligned, press_match, press_mismatch;
  logic             press_stable, rel_stable;
  logic             one_col, is_term, timeout_hit;

  // Two-flop column synchroniser. The row pipeline tracks it so that
  // col_sync is always interpreted against the row that produced it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= KEY_EMPTY;
      col_sync <= KEY_EMPTY;
      row_d1   <= 4'b1110;
      row_d2   <= 4'b1110;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
      row_d1   <= row_out;
      row_d2   <= row_d1;
    end
  end

  // Right after the row is snapped back on detection, col_sync still shows
  // older rows; those cycles are neither matches nor mismatches.
  assign aligned        = (row_d2 == row_out);
  assign press_match    = aligned && (col_sync == key_col);
  assign press_mismatch = aligned && (col_sync != key_col);

  assign key_dec = decode_key(cold_index(key_row), cold_index(key_col));
  assign one_col = ($countones(~key_col) == 1);
  assign is_term = key_dec[4] && ((key_dec[3:0] == KEY_STAR) || (key_dec[3:0] == KEY_HASH));

  teclado_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_press_db (
    .clk     (clk),
    .rst     (rst),
    .sample  (press_match),
    .restart (state != PRESS_DB),
    .stable  (press_stable)
  );

  teclado_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_rel_db (
    .clk     (clk),
    .rst     (rst),
    .sample  (col_sync == KEY_EMPTY),
    .restart (state != REL_DB),
    .stable  (rel_stable)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SCAN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SCAN: begin
        if (col_sync != KEY_EMPTY) state_next = PRESS_DB;
      end
      PRESS_DB: begin
        if (press_mismatch)    state_next = SCAN;
        else if (press_stable) state_next = one_col ? EMIT : REL_DB;
      end
      EMIT:    state_next = is_term ? CLEAR : REL_DB;
      CLEAR:   state_next = REL_DB;
      REL_DB: begin
        if (rel_stable) state_next = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

`ifdef TECLADO_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt;
  logic            idle_counting;

  assign idle_counting = (state == SCAN) && (digitos_value != ALL_EMPTY);
  assign timeout_hit   = idle_counting && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if ((state == EMIT) || timeout_hit) begin
      idle_cnt <= '0;
    end else if (idle_counting) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_out       <= 4'b1110;
      div_cnt       <= '0;
      key_row       <= 4'b1110;
      key_col       <= KEY_EMPTY;
      digitos_value <= ALL_EMPTY;
      digitos_valid <= 1'b0;
    end else begin
      digitos_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (timeout_hit) digitos_value <= ALL_EMPTY;
          if (col_sync != KEY_EMPTY) begin
            // Freeze on the row that actually produced the sampled columns.
            key_row <= row_d2;
            key_col <= col_sync;
            row_out <= row_d2;
            div_cnt <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            row_out <= {row_out[2:0], row_out[3]};
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        EMIT: begin
          if (key_dec[4]) begin
            digitos_value <= {digitos_value.digits[NUM_DIGITS-2:0], key_dec[3:0]};
            digitos_valid <= 1'b1;
          end
        end
        CLEAR: begin
          digitos_value <= ALL_EMPTY;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_teclado_digitos.sv
`default_nettype none
// ============================================================================
// Module      : tb_teclado_digitos
// Description : Self-checking bench for teclado_digitos. A keypad model turns
//               pressed keys into column levels; a digit-history model
//               predicts each pulse and a monitor compares on digitos_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_teclado_digitos;
  import teclado_digitos_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int TO       = 100;
  localparam logic [79:0] ALL_F = {80{1'b1}};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  senhaPac_t  digitos_value;
  logic       digitos_valid;

  teclado_digitos #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .col_in        (col_in),
    .row_out       (row_out),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid)
  );

  always #5 clk = ~clk;

  // Keypad: a column is pulled low when a pressed key sits on a driven row.
  logic pressed [4][4];
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !row_out[r]) col_in[c] = 1'b0;
  end

  // Reference: key legend and a newest-first history of accepted digits.
  int         keymap [4][4];
  logic [3:0] hist[$];
  logic [79:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int pulses = 0;

  function automatic logic [79:0] pack_hist();
    logic [79:0] v;
    v = ALL_F;
    for (int i = 0; i < hist.size(); i++) v[i*4 +: 4] = hist[i];
    return v;
  endfunction

  function automatic void model_key(int r, int c);
    int k;
    k = keymap[r][c];
    if (k < 0) return;
    hist.push_front(4'(k));
    if (hist.size() > 20) void'(hist.pop_back());
    exp_q.push_back(pack_hist());
    if (k == 10 || k == 11) hist.delete();
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  logic prev_valid   = 1'b0;
  logic expect_clear = 1'b0;
  always @(negedge clk) begin
    logic [79:0] e;
    if (!rst) begin
      prev_valid   = 1'b0;
      expect_clear = 1'b0;
    end else begin
      if (expect_clear) begin
        check("clear_after_terminator", digitos_value, ALL_F);
        expect_clear = 1'b0;
      end
      if (digitos_valid) begin
        pulses++;
        check("no_consecutive_valid", 80'(prev_valid), 80'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got pulse with value %h expected no pulse", digitos_value);
        end else begin
          e = exp_q.pop_front();
          check("pulse_value", digitos_value, e);
          if (e[3:0] == 4'hA || e[3:0] == 4'hB) expect_clear = 1'b1;
        end
      end
      prev_valid = digitos_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic press(input int r, input int c, input int hold, input int rel);
    @(posedge clk); #1;
    model_key(r, c);
    pressed[r][c] = 1'b1;
    tick(hold); #1;
    pressed[r][c] = 1'b0;
    tick(rel);
  endtask

  task automatic press_digit(input int d);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keymap[r][c] == d) press(r, c, 40, 30);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    logic [3:0] rot_exp [4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
    keymap[0][0] = 1;  keymap[0][1] = 2; keymap[0][2] = 3;  keymap[0][3] = -1;
    keymap[1][0] = 4;  keymap[1][1] = 5; keymap[1][2] = 6;  keymap[1][3] = -1;
    keymap[2][0] = 7;  keymap[2][1] = 8; keymap[2][2] = 9;  keymap[2][3] = -1;
    keymap[3][0] = 10; keymap[3][1] = 0; keymap[3][2] = 11; keymap[3][3] = -1;
    rot_exp[0] = 4'b1101; rot_exp[1] = 4'b1011; rot_exp[2] = 4'b0111; rot_exp[3] = 4'b1110;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_row_out", 80'(row_out), 80'(4'b1110));
    check("reset_value", digitos_value, ALL_F);
    check("reset_valid", 80'(digitos_valid), 80'(0));

    // Rotation after reset release.
    @(posedge clk); #1 rst = 1'b1;
    n = 0;
    while (row_out == 4'b1110 && n < 10) begin @(negedge clk); n++; end
    check("rotation_0", 80'(row_out), 80'(rot_exp[0]));
    for (int i = 1; i < 4; i++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check($sformatf("rotation_%0d", i), 80'(row_out), 80'(rot_exp[i]));
    end

    // Keys 1, 2, 3.
    p0 = pulses;
    press(0, 0, 40, 30); press(0, 1, 40, 30); press(0, 2, 40, 30);
    check("three_pulses", 80'(pulses - p0), 80'(3));
    check("digits_123", digitos_value, pack_hist());
    press(3, 0, 40, 30);   // '*'

    // Bouncing press of key 7.
    p0 = pulses;
    @(posedge clk); #1;
    model_key(2, 0);
    for (int i = 0; i < 40; i++) begin
      pressed[2][0] = ((i / 3) % 2 == 0);
      tick(1); #1;
    end
    pressed[2][0] = 1'b1;
    tick(40); #1;
    pressed[2][0] = 1'b0;
    tick(30);
    check("bounce_one_pulse", 80'(pulses - p0), 80'(1));

    // Long hold does not repeat.
    p0 = pulses;
    press(2, 1, 500, 30);
    check("hold_one_pulse", 80'(pulses - p0), 80'(1));

    // Letter D and two-column press: no pulse, buffer kept.
    p0 = pulses;
    press(3, 3, 40, 30);
    @(posedge clk); #1;
    pressed[1][0] = 1'b1; pressed[1][1] = 1'b1;
    tick(40); #1;
    pressed[1][0] = 1'b0; pressed[1][1] = 1'b0;
    tick(30);
    check("ignored_no_pulse", 80'(pulses - p0), 80'(0));
    check("ignored_buffer", digitos_value, pack_hist());
    p0 = pulses;
    press(2, 2, 40, 30);
    check("scan_resumes", 80'(pulses - p0), 80'(1));

    // Overflow: 21 digits after a clear.
    press(3, 2, 40, 30);   // '#'
    for (int i = 0; i < 21; i++) press_digit(i % 10);
    check("overflow_digit19", 80'(digitos_value.digits[19]), 80'(4'h1));
    check("overflow_buffer", digitos_value, pack_hist());

    // Randomised keys, including letters and terminators.
    for (int i = 0; i < 20; i++)
      press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(35, 60)), int'($urandom_range(25, 40)));
    check("random_buffer", digitos_value, pack_hist());

    // Asynchronous reset while a key is held.
    press(1, 0, 40, 30);
    @(posedge clk); #1 pressed[1][2] = 1'b1;
    tick(5);
    @(negedge clk); rst = 1'b0; #1;
    check("midreset_row_out", 80'(row_out), 80'(4'b1110));
    check("midreset_value", digitos_value, ALL_F);
    check("midreset_valid", 80'(digitos_valid), 80'(0));
    pressed[1][2] = 1'b0;
    hist.delete();
    exp_q.delete();
    tick(3); #1 rst = 1'b1;
    tick(5);

    // Idle behaviour after key 5.
    press(1, 1, 40, 30);
    tick(150);
`ifdef TECLADO_TIMEOUT_EN
    hist.delete();
`endif
    @(negedge clk);
    check("idle_buffer", digitos_value, pack_hist());

    tick(20);
    check("pending_pulses", 80'(exp_q.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
